amo_sequencer: RTL and testbench
================================

Name: amo_sequencer

Overview:
- Multi-cycle execute-stage block that consumes the decoded RV32A control (LR, SC, AMO op, reserve/exclusive intent) produced by the control unit.
- Turns each accepted atomic into the read / modify / write sequence on the data bus.
- Owns the single-entry reservation set and returns the rd result to writeback.
- Sits between the decode-to-execute boundary and the data-side generic bus port; the pipeline stalls on !req_ready / busy.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width (fixed at 32 for RV32)

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
req_valid  input  1  atomic request from execute stage
req_ready  output  1  high only in IDLE; request accepted when req_valid & req_ready
req_op  input  4  0 LR, 1 SC, 2 SWAP, 3 ADD, 4 XOR, 5 AND, 6 OR, 7 MIN, 8 MAX, 9 MINU, 10 MAXU; 11-15 illegal
req_addr  input  ADDR_W  byte address (rs1)
req_data  input  DATA_W  rs2 operand
busy  output  1  sequence in progress (not IDLE)
done  output  1  one-cycle completion pulse
fault  output  1  valid with done: misaligned address or illegal op
rd_data  output  DATA_W  valid with done
mem_ren  output  1  bus read strobe
mem_wen  output  1  bus write strobe
mem_addr  output  ADDR_W  word-aligned bus address
mem_wdata  output  DATA_W  bus write data
mem_rdata  input  DATA_W  bus read data, valid when mem_ren & !mem_busy
mem_busy  input  1  bus wait; transfer completes in the cycle it is low
snoop_wen  input  1  store by another agent or the pipeline
snoop_addr  input  ADDR_W  address of that store
resv_valid  output  1  reservation held (debug/verification)

Behaviour:
- Reset: state IDLE; req_ready=1; busy, done, fault, mem_ren, mem_wen, resv_valid = 0; rd_data, mem_addr, mem_wdata = 0; reservation address cleared.
- RST in any state returns to IDLE next edge. Strobes drop immediately (registered to 0) and the reservation is cleared. No done pulse is produced for the aborted op.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On accept, op, addr and data are registered.
  - addr[1:0]!=0 or op>10 -> DONE with fault=1; no bus access.
  - LR or AMO -> READ.
  - SC with resv_valid and resv_addr==addr[31:2] -> WRITE (mem_wdata=req_data).
  - SC without a match -> DONE with rd_data=1; the reservation is cleared either way.
- READ:
  - mem_ren=1 and mem_addr={addr[31:2],2'b00} are held stable while mem_busy=1.
  - On mem_busy=0, mem_rdata is captured as old.
  - LR: set reservation to addr[31:2], rd_data=old -> DONE.
  - AMO: compute new = f(old, req_data) into mem_wdata register -> WRITE.
- Arithmetic:
  - ADD wraps modulo 2^32.
  - MIN/MAX are signed 32-bit compares; MINU/MAXU are unsigned.
  - SWAP: new = req_data.
  - Ties select old.
- WRITE:
  - mem_wen=1 with stable address and data until mem_busy=0.
  - Then -> DONE with rd_data=old for AMO, 0 for SC.
  - An AMO or SC write to the reserved word clears the reservation.
- DONE: done=1 for exactly one cycle, rd_data/fault valid, busy=1; -> IDLE. rd_data holds its value until the next done.
- mem_ren and mem_wen are never high together. Strobes are high only in READ/WRITE respectively.
- Snoop:
  - snoop_wen with snoop_addr[31:2]==resv_addr clears resv_valid next edge, in any state.
  - A snoop in the same cycle as LR completion to the same word leaves the reservation clear (snoop wins).
  - A snoop in the IDLE cycle an SC is accepted makes that SC fail.
- Latency with zero-wait bus: LR done at cycle 2 after accept; AMO at 3; successful SC at 2; failed SC or fault at 1. Each bus wait cycle adds one.

Test Plan:
- Mem word 0x100 = 5; LR 0x100 then SC 0x100 data 9 -> LR rd=5, resv_valid=1; SC writes 9, rd=0, resv_valid=0, done 2 cycles after each accept.
- LR 0x200; snoop_wen to 0x202 next cycle; SC 0x200 -> SC rd=1, no mem_wen asserted, mem unchanged.
- AMOADD 0x300 with mem=0xFFFFFFFF, data=2 -> write 0x00000001, rd=0xFFFFFFFF. AMOMIN with mem=0x80000000, data=1 -> write 0x80000000. AMOMINU on the same values -> write 1.
- AMOSWAP addr 0x102 -> done one cycle after accept, fault=1, no strobes. op=12 -> fault=1.
- AMOOR with mem_busy held 3 cycles in READ and 2 in WRITE -> address and data stable throughout, done at cycle 8, req_ready low until after DONE.
- RST asserted during WRITE with a reservation held -> next cycle IDLE, strobes 0, resv_valid=0, no done pulse.

Source files
------------

// File: rtl/amo_sequencer.sv
// RV32A atomic sequencer: runs LR/SC/AMO read-modify-write on the data bus and owns the reservation.
// Latency: LR 2, AMO 3, SC-hit 2, SC-miss/fault 1 cycles + bus waits; req_ready low while busy, bus stalls via mem_busy.
module amo_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy,
    input  logic              snoop_wen,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              resv_valid
);
    localparam int WA = ADDR_W - 2;

    localparam logic [3:0] OP_LR   = 4'd0;
    localparam logic [3:0] OP_SC   = 4'd1;
    localparam logic [3:0] OP_SWAP = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_MIN  = 4'd7;
    localparam logic [3:0] OP_MAX  = 4'd8;
    localparam logic [3:0] OP_MINU = 4'd9;
    localparam logic [3:0] OP_MAXU = 4'd10;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        op_q;
    logic [WA-1:0]     addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] old_q;
    logic              fault_q;
    logic [WA-1:0]     resv_addr;

    logic              accept;
    logic              req_bad;
    logic              snoop_cur;
    logic              snoop_new;
    logic              sc_hit;
    logic              resv_set;
    logic              resv_clr;
    logic [DATA_W-1:0] amo_new;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign fault     = fault_q && (state == DONE);
    assign mem_ren   = (state == READ);
    assign mem_wen   = (state == WRITE);

    assign accept    = req_valid && (state == IDLE);
    assign req_bad   = (req_addr[1:0] != 2'b00) || (req_op > OP_MAXU);
    assign snoop_cur = snoop_wen && resv_valid && (snoop_addr[ADDR_W-1:2] == resv_addr);
    assign snoop_new = snoop_wen && (snoop_addr[ADDR_W-1:2] == addr_q);
    // A store landing on the reserved word in the accept cycle already kills the SC.
    assign sc_hit    = resv_valid && (resv_addr == req_addr[ADDR_W-1:2]) && !snoop_cur;
    assign resv_set  = (state == READ) && !mem_busy && (op_q == OP_LR);
    assign resv_clr  = (accept && !req_bad && (req_op == OP_SC))
                    || ((state == WRITE) && !mem_busy && (addr_q == resv_addr))
                    || snoop_cur;

    always_comb begin
        amo_new = data_q;
        case (op_q)
            OP_SWAP: amo_new = data_q;
            OP_ADD:  amo_new = mem_rdata + data_q;
            OP_XOR:  amo_new = mem_rdata ^ data_q;
            OP_AND:  amo_new = mem_rdata & data_q;
            OP_OR:   amo_new = mem_rdata | data_q;
            OP_MIN:  amo_new = ($signed(data_q) < $signed(mem_rdata)) ? data_q : mem_rdata;
            OP_MAX:  amo_new = ($signed(data_q) > $signed(mem_rdata)) ? data_q : mem_rdata;
            OP_MINU: amo_new = (data_q < mem_rdata) ? data_q : mem_rdata;
            OP_MAXU: amo_new = (data_q > mem_rdata) ? data_q : mem_rdata;
            default: amo_new = data_q;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad)                 state_nxt = DONE;
                    else if (req_op != OP_SC)    state_nxt = READ;
                    else if (sc_hit)             state_nxt = WRITE;
                    else                         state_nxt = DONE;
                end
            end
            READ:    if (!mem_busy) state_nxt = (op_q == OP_LR) ? DONE : WRITE;
            WRITE:   if (!mem_busy) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q      <= OP_LR;
            addr_q    <= '0;
            data_q    <= '0;
            old_q     <= '0;
            fault_q   <= 1'b0;
            rd_data   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        addr_q   <= req_addr[ADDR_W-1:2];
                        data_q   <= req_data;
                        mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                        fault_q  <= req_bad;
                        if (req_bad)
                            rd_data <= '0;
                        else if (req_op == OP_SC && sc_hit)
                            mem_wdata <= req_data;
                        else if (req_op == OP_SC)
                            rd_data <= DATA_W'(1);
                    end
                end
                READ: begin
                    if (!mem_busy) begin
                        old_q <= mem_rdata;
                        if (op_q == OP_LR) rd_data   <= mem_rdata;
                        else               mem_wdata <= amo_new;
                    end
                end
                WRITE: begin
                    if (!mem_busy) rd_data <= (op_q == OP_SC) ? '0 : old_q;
                end
                default: ;
            endcase
        end
    end

    // Snoop beats a same-cycle LR completion so the fresh reservation never appears.
    always_ff @(posedge CLK) begin
        if (RST) begin
            resv_valid <= 1'b0;
            resv_addr  <= '0;
        end else if (resv_set) begin
            resv_valid <= !snoop_new;
            resv_addr  <= addr_q;
        end else if (resv_clr) begin
            resv_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_amo_sequencer.sv
// Scoreboarded bench for amo_sequencer with a wait-state-programmable word memory model.
module tb_amo_sequencer;
    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        busy, done, fault;
    logic [31:0] rd_data;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_busy;
    logic        snoop_wen;
    logic [31:0] snoop_addr;
    logic        resv_valid;

    amo_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .busy(busy), .done(done), .fault(fault), .rd_data(rd_data),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .snoop_wen(snoop_wen), .snoop_addr(snoop_addr), .resv_valid(resv_valid)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [0:1023];
    logic        poke_vld;
    logic [31:0] poke_addr, poke_dat;
    int          rd_wait_cfg, wr_wait_cfg;
    int          rd_cnt = 0, wr_cnt = 0;
    int          ren_cycles = 0, wen_cycles = 0;

    assign mem_rdata = mem[mem_addr[11:2]];
    assign mem_busy  = (mem_ren && rd_cnt < rd_wait_cfg) || (mem_wen && wr_cnt < wr_wait_cfg);

    always @(posedge CLK) begin
        rd_cnt <= (mem_ren && mem_busy) ? rd_cnt + 1 : 0;
        wr_cnt <= (mem_wen && mem_busy) ? wr_cnt + 1 : 0;
        if (mem_ren) ren_cycles <= ren_cycles + 1;
        if (mem_wen) wen_cycles <= wen_cycles + 1;
        if (poke_vld)                 mem[poke_addr[11:2]] <= poke_dat;
        else if (mem_wen && !mem_busy) mem[mem_addr[11:2]] <= mem_wdata;
    end

    typedef struct {
        logic [31:0] rd;
        logic        f;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_pass = 0;
    int n_total = 0;

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        poke_vld = 1'b1; poke_addr = a; poke_dat = d;
        @(posedge CLK); #1;
        poke_vld = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] rd, input logic f, input int lat);
        exp_t e;
        e.rd = rd; e.f = f; e.lat = lat;
        sb.push_back(e);
    endtask

    // Issues one request and returns what the DUT reported at its done pulse (lat=-1 on timeout).
    task automatic run_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic f, output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin @(posedge CLK); #1; guard++; end
        req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin @(posedge CLK); #1; lat++; end
        rd = rd_data; f = fault;
        if (!done) lat = -1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready act=%b req=1", req_ready); else n_pass++;
        n_total++; if ({busy, done, fault} !== 3'b000) $display("FAIL reset_busy_done_fault act=%b req=000", {busy, done, fault}); else n_pass++;
        n_total++; if ({mem_ren, mem_wen, resv_valid} !== 3'b000) $display("FAIL reset_strobes_resv act=%b req=000", {mem_ren, mem_wen, resv_valid}); else n_pass++;
        n_total++; if ({rd_data, mem_addr, mem_wdata} !== 96'h0) $display("FAIL reset_data act=%h req=0", {rd_data, mem_addr, mem_wdata}); else n_pass++;
    endtask

    task automatic test_lr_sc;
        logic [31:0] rd; logic f; int lat; exp_t e;
        poke(32'h100, 32'd5);
        push_exp(32'd5, 1'b0, 2);
        run_req(4'd0, 32'h100, 32'd0, rd, f, lat);
        e = sb.pop_front();
        n_total++; if (rd !== e.rd) $display("FAIL lr_rd act=%h req=%h", rd, e.rd); else n_pass++;
        n_total++; if (lat !== e.lat) $display("FAIL lr_latency act=%0d req=%0d", lat, e.lat); else n_pass++;
        n_total++; if (resv_valid !== 1'b1) $display("FAIL lr_resv act=%b req=1", resv_valid); else n_pass++;
        push_exp(32'd0, 1'b0, 2);
        run_req(4'd1, 32'h100, 32'd9, rd, f, lat);
        e = sb.pop_front();
        n_total++; if (rd !== e.rd) $display("FAIL sc_rd act=%h req=%h", rd, e.rd); else n_pass++;
        n_total++; if (lat !== e.lat) $display("FAIL sc_latency act=%0d req=%0d", lat, e.lat); else n_pass++;
        n_total++; if (resv_valid !== 1'b0) $display("FAIL sc_resv act=%b req=0", resv_valid); else n_pass++;
        n_total++; if (mem[32'h100 >> 2] !== 32'd9) $display("FAIL sc_mem act=%h req=9", mem[32'h100 >> 2]); else n_pass++;
    endtask

    task automatic test_snoop;
        logic [31:0] rd; logic f; int lat; exp_t e; int wen0;
        poke(32'h200, 32'h55);
        push_exp(32'h55, 1'b0, 2);
        run_req(4'd0, 32'h200, 32'd0, rd, f, lat);
        e = sb.pop_front();
        n_total++; if (rd !== e.rd) $display("FAIL snoop_lr_rd act=%h req=%h", rd, e.rd); else n_pass++;
        snoop_wen = 1'b1; snoop_addr = 32'h202;
        @(posedge CLK); #1;
        snoop_wen = 1'b0;
        n_total++; if (resv_valid !== 1'b0) $display("FAIL snoop_clear act=%b req=0", resv_valid); else n_pass++;
        wen0 = wen_cycles;
        push_exp(32'd1, 1'b0, 1);
        run_req(4'd1, 32'h200, 32'd7, rd, f, lat);
        e = sb.pop_front();
        n_total++; if (rd !== e.rd) $display("FAIL snoop_sc_rd act=%h req=%h", rd, e.rd); else n_pass++;
        n_total++; if (lat !== e.lat) $display("FAIL snoop_sc_latency act=%0d req=%0d", lat, e.lat); else n_pass++;
        n_total++; if (wen_cycles !== wen0) $display("FAIL snoop_sc_wen act=%0d req=%0d", wen_cycles, wen0); else n_pass++;
        n_total++; if (mem[32'h200 >> 2] !== 32'h55) $display("FAIL snoop_mem act=%h req=55", mem[32'h200 >> 2]); else n_pass++;
    endtask

    task automatic test_amo_arith;
        logic [3:0]  ops  [8] = '{4'd3, 4'd7, 4'd9, 4'd4, 4'd5, 4'd8, 4'd10, 4'd2};
        logic [31:0] olds [8] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h0000F0F0,
                                  32'h0000F0F0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
        logic [31:0] ins  [8] = '{32'd2, 32'd1, 32'd1, 32'h00000FF0,
                                  32'h00000FF0, 32'd3, 32'd3, 32'h000000AA};
        logic [31:0] news [8] = '{32'h00000001, 32'h80000000, 32'h00000001, 32'h0000FF00,
                                  32'h000000F0, 32'h00000003, 32'hFFFFFFFF, 32'h000000AA};
        logic [31:0] rd; logic f; int lat; exp_t e;
        for (int i = 0; i < 8; i++) begin
            poke(32'h300, olds[i]);
            push_exp(olds[i], 1'b0, 3);
            run_req(ops[i], 32'h300, ins[i], rd, f, lat);
            e = sb.pop_front();
            n_total++; if (rd !== e.rd) $display("FAIL amo_rd op=%0d act=%h req=%h", ops[i], rd, e.rd); else n_pass++;
            n_total++; if (lat !== e.lat || f !== e.f) $display("FAIL amo_lat_fault op=%0d act=%0d/%b req=%0d/%b", ops[i], lat, f, e.lat, e.f); else n_pass++;
            n_total++; if (mem[32'h300 >> 2] !== news[i]) $display("FAIL amo_mem op=%0d act=%h req=%h", ops[i], mem[32'h300 >> 2], news[i]); else n_pass++;
        end
    endtask

    task automatic test_fault;
        logic [31:0] rd; logic f; int lat; exp_t e; int strobes0;
        strobes0 = ren_cycles + wen_cycles;
        push_exp(32'd0, 1'b1, 1);
        run_req(4'd2, 32'h102, 32'h77, rd, f, lat);
        e = sb.pop_front();
        n_total++; if (f !== e.f) $display("FAIL misalign_fault act=%b req=%b", f, e.f); else n_pass++;
        n_total++; if (lat !== e.lat) $display("FAIL misalign_latency act=%0d req=%0d", lat, e.lat); else n_pass++;
        push_exp(32'd0, 1'b1, 1);
        run_req(4'd12, 32'h100, 32'h77, rd, f, lat);
        e = sb.pop_front();
        n_total++; if (f !== e.f || lat !== e.lat) $display("FAIL illegal_op act=%b/%0d req=%b/%0d", f, lat, e.f, e.lat); else n_pass++;
        n_total++; if (ren_cycles + wen_cycles !== strobes0) $display("FAIL fault_strobes act=%0d req=%0d", ren_cycles + wen_cycles, strobes0); else n_pass++;
        n_total++; if (mem[32'h100 >> 2] !== 32'd9) $display("FAIL fault_mem act=%h req=9", mem[32'h100 >> 2]); else n_pass++;
    endtask

    task automatic test_bus_wait;
        exp_t e; int bad_rd, bad_wr, bad_rdy, done_at;
        poke(32'h340, 32'h0000_00F0);
        rd_wait_cfg = 3; wr_wait_cfg = 2;
        push_exp(32'h0000_00F0, 1'b0, 8);
        req_valid = 1'b1; req_op = 4'd6; req_addr = 32'h340; req_data = 32'h0000_0F0F;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        bad_rd = 0; bad_wr = 0; bad_rdy = 0; done_at = -1;
        for (int c = 1; c <= 8; c++) begin
            if (req_ready) bad_rdy++;
            if (c <= 4 && !(mem_ren && !mem_wen && mem_addr == 32'h340)) bad_rd++;
            if (c >= 5 && c <= 7 && !(mem_wen && !mem_ren && mem_addr == 32'h340 && mem_wdata == 32'h0000_0FFF)) bad_wr++;
            if (done && done_at < 0) done_at = c;
            if (c < 8) begin @(posedge CLK); #1; end
        end
        e = sb.pop_front();
        n_total++; if (bad_rd !== 0) $display("FAIL wait_read_stable act=%0d bad cycles req=0", bad_rd); else n_pass++;
        n_total++; if (bad_wr !== 0) $display("FAIL wait_write_stable act=%0d bad cycles req=0", bad_wr); else n_pass++;
        n_total++; if (bad_rdy !== 0) $display("FAIL wait_req_ready act=%0d high cycles req=0", bad_rdy); else n_pass++;
        n_total++; if (done_at !== e.lat) $display("FAIL wait_latency act=%0d req=%0d", done_at, e.lat); else n_pass++;
        n_total++; if (rd_data !== e.rd) $display("FAIL wait_rd act=%h req=%h", rd_data, e.rd); else n_pass++;
        @(posedge CLK); #1;
        n_total++; if (req_ready !== 1'b1 || done !== 1'b0) $display("FAIL wait_after_done act=%b%b req=10", req_ready, done); else n_pass++;
        n_total++; if (mem[32'h340 >> 2] !== 32'h0000_0FFF) $display("FAIL wait_mem act=%h req=00000fff", mem[32'h340 >> 2]); else n_pass++;
        rd_wait_cfg = 0; wr_wait_cfg = 0;
    endtask

    task automatic test_reset_in_write;
        logic [31:0] rd; logic f; int lat; exp_t e; int guard, dones;
        poke(32'h400, 32'd10);
        push_exp(32'd10, 1'b0, 2);
        run_req(4'd0, 32'h400, 32'd0, rd, f, lat);
        e = sb.pop_front();
        n_total++; if (resv_valid !== 1'b1 || rd !== e.rd) $display("FAIL rstw_lr act=%b/%h req=1/%h", resv_valid, rd, e.rd); else n_pass++;
        wr_wait_cfg = 10;
        @(posedge CLK); #1;
        req_valid = 1'b1; req_op = 4'd3; req_addr = 32'h400; req_data = 32'd1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!mem_wen && guard < 20) begin @(posedge CLK); #1; guard++; end
        n_total++; if (mem_wen !== 1'b1) $display("FAIL rstw_reach_write act=%b req=1", mem_wen); else n_pass++;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        n_total++; if ({busy, mem_ren, mem_wen, resv_valid, done} !== 5'b0) $display("FAIL rstw_state act=%b req=00000", {busy, mem_ren, mem_wen, resv_valid, done}); else n_pass++;
        n_total++; if (req_ready !== 1'b1) $display("FAIL rstw_ready act=%b req=1", req_ready); else n_pass++;
        dones = 0;
        for (int c = 0; c < 4; c++) begin @(posedge CLK); #1; if (done) dones++; end
        n_total++; if (dones !== 0) $display("FAIL rstw_no_done act=%0d req=0", dones); else n_pass++;
        n_total++; if (mem[32'h400 >> 2] !== 32'd10) $display("FAIL rstw_mem act=%h req=a", mem[32'h400 >> 2]); else n_pass++;
        wr_wait_cfg = 0;
    endtask

    initial begin
        RST = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_addr = '0; req_data = '0;
        snoop_wen = 1'b0; snoop_addr = '0; poke_vld = 1'b0; poke_addr = '0; poke_dat = '0;
        rd_wait_cfg = 0; wr_wait_cfg = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset;
        test_lr_sc;
        test_snoop;
        test_amo_arith;
        test_fault;
        test_bus_wait;
        test_reset_in_write;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
